// File: rtl/rv32_ctrl_pkg.sv
// rv32_ctrl_pkg: shared states, opcodes, mux selects and ALU codes for the multicycle controller
package rv32_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_A        = 2'b10;
    localparam logic [1:0] SRCB_WD       = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] IMM_I         = 2'b00;
    localparam logic [1:0] IMM_S         = 2'b01;
    localparam logic [1:0] IMM_B         = 2'b10;
    localparam logic [1:0] IMM_J         = 2'b11;
    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT   = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       fetch;
        logic       decode;
        logic       beq;
        logic       jal;
    } ctrl_t;

    function automatic logic op_legal(logic [6:0] op);
        return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BEQ || op == OP_JAL;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields, status inputs and control outputs between controller and datapath
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       RegWrite;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, Illegal, State
    );

    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ImmSrc, ALUControl, RegWrite, Illegal, State
    );
endinterface

// File: rtl/multicycle_controller_aludec.sv
// aludec: maps ALUOp plus instruction fields to the ALU operation code
module aludec
    import rv32_ctrl_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] alu_op,
    output logic [2:0] alu_control
);
    // only funct-decoded ops look at funct3; unknown funct3 quietly falls back to add
    always_comb
        alu_control = alu_op == ALUOP_SUB     ? ALU_SUB :
                      alu_op != ALUOP_FUNCT   ? ALU_ADD :
                      funct3 == 3'b000        ? ((op5 && funct7b5) ? ALU_SUB : ALU_ADD) :
                      funct3 == 3'b010        ? ALU_SLT :
                      funct3 == 3'b110        ? ALU_OR  :
                      funct3 == 3'b111        ? ALU_AND : ALU_ADD;
endmodule

// File: rtl/multicycle_controller_mainfsm.sv
// mainfsm: instruction sequencing state machine with registered Moore controls
module mainfsm
    import rv32_ctrl_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       ready,
    input  logic       zero,
    output state_t     state,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       illegal,
    output logic       adr_src,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op
);
    ctrl_t  ctrl;
    state_t nxt;

    function automatic state_t next_state(state_t s, logic [6:0] o, logic rdy);
        state_t n;
        case (s)
            S_FETCH:    n = rdy ? S_DECODE : S_FETCH;
            S_DECODE:   n = (o == OP_LW || o == OP_SW) ? S_MEMADR :
                            o == OP_R   ? S_EXECR :
                            o == OP_I   ? S_EXECI :
                            o == OP_BEQ ? S_BEQ   :
                            o == OP_JAL ? S_JAL   : S_FETCH;
            S_MEMADR:   n = o[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  n = rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: n = rdy ? S_FETCH : S_MEMWRITE;
            S_EXECR, S_EXECI, S_JAL: n = S_ALUWB;
            default:    n = S_FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t moore(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.fetch = 1'b1; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURESULT; end
            S_DECODE:   begin c.decode = 1'b1; c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
            S_MEMADR:   begin c.alu_src_a = SRCA_A; c.alu_src_b = SRCB_IMM; end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; end
            S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            S_EXECR:    begin c.alu_src_a = SRCA_A; c.alu_src_b = SRCB_WD; c.alu_op = ALUOP_FUNCT; end
            S_EXECI:    begin c.alu_src_a = SRCA_A; c.alu_src_b = SRCB_IMM; c.alu_op = ALUOP_FUNCT; end
            S_ALUWB:    c.reg_write = 1'b1;
            S_BEQ:      begin c.beq = 1'b1; c.alu_src_a = SRCA_A; c.alu_src_b = SRCB_WD; c.alu_op = ALUOP_SUB; end
            S_JAL:      begin c.jal = 1'b1; c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    // next state from the current state, opcode and memory handshake
    always_comb nxt = next_state(state, op, ready);

    // controls are decoded from the incoming state so they are registered alongside it
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RESET_STATE;
            ctrl  <= moore(RESET_STATE);
        end else begin
            state <= nxt;
            ctrl  <= moore(nxt);
        end
    end

    assign pc_write   = !reset && ((ctrl.fetch && ready) || (ctrl.beq && zero) || ctrl.jal);
    assign ir_write   = !reset && ctrl.fetch && ready;
    assign mem_write  = !reset && ctrl.mem_write;
    assign reg_write  = !reset && ctrl.reg_write;
    assign illegal    = !reset && ctrl.decode && !op_legal(op);
    assign adr_src    = ctrl.adr_src;
    assign result_src = ctrl.result_src;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control unit for the multicycle RV32I datapath
module multicycle_controller
    import rv32_ctrl_pkg::*;
#(
    parameter int     MEM_HANDSHAKE = 1,
    parameter state_t RESET_STATE   = S_FETCH
) (
    input logic                    clk,
    input logic                    reset,
    multicycle_controller_if.master bus
);
    logic       ready;
    logic [1:0] alu_op;
    state_t     state;

    assign ready = MEM_HANDSHAKE != 0 ? bus.MemReady : 1'b1;

    mainfsm #(.RESET_STATE(RESET_STATE)) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .op         (bus.op),
        .ready      (ready),
        .zero       (bus.Zero),
        .state      (state),
        .pc_write   (bus.PCWrite),
        .ir_write   (bus.IRWrite),
        .mem_write  (bus.MemWrite),
        .reg_write  (bus.RegWrite),
        .illegal    (bus.Illegal),
        .adr_src    (bus.AdrSrc),
        .result_src (bus.ResultSrc),
        .alu_src_a  (bus.ALUSrcA),
        .alu_src_b  (bus.ALUSrcB),
        .alu_op     (alu_op)
    );

    aludec u_alu (
        .op5         (bus.op[5]),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .alu_op      (alu_op),
        .alu_control (bus.ALUControl)
    );

    assign bus.State  = state;
    assign bus.ImmSrc = bus.op == OP_SW  ? IMM_S :
                        bus.op == OP_BEQ ? IMM_B :
                        bus.op == OP_JAL ? IMM_J : IMM_I;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed and randomized checks of the controller against an instruction-level model
module tb_multicycle_controller;
    import rv32_ctrl_pkg::*;

    localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_JAL = 5, C_ILL = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multicycle_controller_if bus();
    multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

    int     n_chk = 0;
    int     n_fail = 0;
    bit     chk_en = 1'b0;
    int     step = 0;
    state_t cs;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cls_of(logic [6:0] o);
        return o == OP_LW ? C_LW : o == OP_SW ? C_SW : o == OP_R ? C_R : o == OP_I ? C_I :
               o == OP_BEQ ? C_BEQ : o == OP_JAL ? C_JAL : C_ILL;
    endfunction

    // cycles an instruction takes when memory never stalls
    function automatic int len_of(int c);
        return c == C_LW ? 5 : c == C_BEQ ? 3 : c == C_ILL ? 2 : 4;
    endfunction

    // step-by-step phase list of each instruction class
    function automatic state_t stage_of(int c, int s);
        state_t t[5];
        case (c)
            C_LW:    t = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
            C_SW:    t = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMWRITE, S_FETCH};
            C_R:     t = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB, S_FETCH};
            C_I:     t = '{S_FETCH, S_DECODE, S_EXECI, S_ALUWB, S_FETCH};
            C_BEQ:   t = '{S_FETCH, S_DECODE, S_BEQ, S_FETCH, S_FETCH};
            C_JAL:   t = '{S_FETCH, S_DECODE, S_JAL, S_ALUWB, S_FETCH};
            default: t = '{S_FETCH, S_DECODE, S_FETCH, S_FETCH, S_FETCH};
        endcase
        return t[s];
    endfunction

    function automatic int alu_exp(state_t s, logic [6:0] o, logic [2:0] f3, logic f7);
        if (s == S_BEQ) return 1;
        if (s != S_EXECR && s != S_EXECI) return 0;
        case (f3)
            3'b000:  return (o[5] && f7) ? 1 : 0;
            3'b010:  return 5;
            3'b110:  return 3;
            3'b111:  return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int imm_exp(logic [6:0] o);
        return o == OP_SW ? 1 : o == OP_BEQ ? 2 : o == OP_JAL ? 3 : 0;
    endfunction

    // model: advance one phase per cycle, holding in memory phases until MemReady
    always @(posedge clk) begin
        if (reset)
            step <= 0;
        else if (!((stage_of(cls_of(bus.op), step) inside {S_FETCH, S_MEMREAD, S_MEMWRITE}) && !bus.MemReady))
            step <= (step + 1 == len_of(cls_of(bus.op))) ? 0 : step + 1;
    end

    // compare every output against the model mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            cs = stage_of(cls_of(bus.op), step);
            chk("State", int'(bus.State), int'(cs));
            chk("PCWrite", int'(bus.PCWrite), int'(!reset && ((cs == S_FETCH && bus.MemReady) || (cs == S_BEQ && bus.Zero) || cs == S_JAL)));
            chk("IRWrite", int'(bus.IRWrite), int'(!reset && cs == S_FETCH && bus.MemReady));
            chk("MemWrite", int'(bus.MemWrite), int'(!reset && cs == S_MEMWRITE));
            chk("RegWrite", int'(bus.RegWrite), int'(!reset && (cs == S_MEMWB || cs == S_ALUWB)));
            chk("Illegal", int'(bus.Illegal), int'(!reset && cs == S_DECODE && cls_of(bus.op) == C_ILL));
            chk("AdrSrc", int'(bus.AdrSrc), int'(cs == S_MEMREAD || cs == S_MEMWRITE));
            chk("ResultSrc", int'(bus.ResultSrc), cs == S_FETCH ? 2 : cs == S_MEMWB ? 1 : 0);
            chk("ALUSrcA", int'(bus.ALUSrcA), (cs == S_DECODE || cs == S_JAL) ? 1 :
                (cs inside {S_MEMADR, S_EXECR, S_EXECI, S_BEQ}) ? 2 : 0);
            chk("ALUSrcB", int'(bus.ALUSrcB), (cs == S_FETCH || cs == S_JAL) ? 2 :
                (cs inside {S_DECODE, S_MEMADR, S_EXECI}) ? 1 : 0);
            chk("ALUControl", int'(bus.ALUControl), alu_exp(cs, bus.op, bus.funct3, bus.funct7b5));
            chk("ImmSrc", int'(bus.ImmSrc), imm_exp(bus.op));
        end
    end

    task automatic drive(input logic r, input logic rdy, input logic z, input logic [6:0] o,
                         input logic [2:0] f3, input logic f7);
        @(posedge clk);
        #1;
        reset = r;
        bus.MemReady = rdy;
        bus.Zero = z;
        bus.op = o;
        bus.funct3 = f3;
        bus.funct7b5 = f7;
        @(negedge clk);
    endtask

    initial begin
        int lw_st[6];
        int sw_st[8];
        logic sw_rdy[8];
        int k;
        lw_st = '{0, 1, 2, 3, 4, 0};
        sw_st = '{0, 1, 2, 5, 5, 5, 5, 0};
        sw_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bus.MemReady = 1'b1;
        bus.Zero = 1'b0;
        bus.op = OP_LW;
        bus.funct3 = 3'b000;
        bus.funct7b5 = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;

        drive(1, 1, 0, OP_LW, 0, 0);
        chk("rst_state", int'(bus.State), 0);
        chk("rst_irwrite", int'(bus.IRWrite), 0);
        chk("rst_pcwrite", int'(bus.PCWrite), 0);
        chk("rst_srcb", int'(bus.ALUSrcB), 2);
        chk("rst_result", int'(bus.ResultSrc), 2);

        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 0, OP_LW, 0, 0);
            chk("lw_state", int'(bus.State), lw_st[i]);
            chk("lw_regwrite", int'(bus.RegWrite), i == 4 ? 1 : 0);
            if (i == 4) chk("lw_result", int'(bus.ResultSrc), 1);
        end

        drive(1, 1, 0, OP_SW, 0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(0, sw_rdy[i], 0, OP_SW, 0, 0);
            chk("sw_state", int'(bus.State), sw_st[i]);
            if (i >= 3 && i <= 6) begin
                chk("sw_memwrite", int'(bus.MemWrite), 1);
                chk("sw_adrsrc", int'(bus.AdrSrc), 1);
                chk("sw_pcwrite", int'(bus.PCWrite), 0);
            end
        end

        for (int f = 1; f >= 0; f--) begin
            drive(1, 1, 0, OP_R, 0, f[0]);
            drive(0, 1, 0, OP_R, 0, f[0]);
            drive(0, 1, 0, OP_R, 0, f[0]);
            drive(0, 1, 0, OP_R, 0, f[0]);
            chk("r_state", int'(bus.State), 6);
            chk("r_aluctl", int'(bus.ALUControl), f == 1 ? 1 : 0);
            drive(0, 1, 0, OP_R, 0, f[0]);
            chk("r_regwrite", int'(bus.RegWrite), 1);
            drive(0, 1, 0, OP_R, 0, f[0]);
            chk("r_done", int'(bus.RegWrite), 0);
        end

        for (int z = 1; z >= 0; z--) begin
            drive(1, 1, z[0], OP_BEQ, 0, 0);
            drive(0, 1, z[0], OP_BEQ, 0, 0);
            drive(0, 1, z[0], OP_BEQ, 0, 0);
            drive(0, 1, z[0], OP_BEQ, 0, 0);
            chk("beq_state", int'(bus.State), 9);
            chk("beq_pcwrite", int'(bus.PCWrite), z);
            chk("beq_immsrc", int'(bus.ImmSrc), 2);
            drive(0, 0, z[0], OP_BEQ, 0, 0);
            chk("beq_back", int'(bus.State), 0);
        end

        drive(1, 1, 0, 7'b1110011, 0, 0);
        drive(0, 1, 0, 7'b1110011, 0, 0);
        chk("ill_fetch", int'(bus.Illegal), 0);
        drive(0, 1, 0, 7'b1110011, 0, 0);
        chk("ill_pulse", int'(bus.Illegal), 1);
        chk("ill_writes", int'({bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.IRWrite}), 0);
        drive(0, 1, 0, 7'b1110011, 0, 0);
        chk("ill_state", int'(bus.State), 0);
        chk("ill_clear", int'(bus.Illegal), 0);

        drive(1, 1, 0, OP_SW, 0, 0);
        drive(0, 1, 0, OP_SW, 0, 0);
        drive(0, 1, 0, OP_SW, 0, 0);
        drive(0, 1, 0, OP_SW, 0, 0);
        drive(0, 0, 0, OP_SW, 0, 0);
        chk("mr_memwrite", int'(bus.MemWrite), 1);
        drive(1, 0, 0, OP_SW, 0, 0);
        chk("mr_rst_memwrite", int'(bus.MemWrite), 0);
        chk("mr_rst_state", int'(bus.State), 5);
        drive(0, 0, 0, OP_SW, 0, 0);
        chk("mr_state", int'(bus.State), 0);
        chk("mr_irwrite0", int'(bus.IRWrite), 0);
        drive(0, 1, 0, OP_SW, 0, 0);
        chk("mr_irwrite1", int'(bus.IRWrite), 1);

        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            if (step == 0) begin
                k = $urandom_range(0, 7);
                bus.op = k == 0 ? OP_LW : k == 1 ? OP_SW : k == 2 ? OP_R : k == 3 ? OP_I :
                         k == 4 ? OP_BEQ : k == 5 ? OP_JAL : 7'($urandom);
                bus.funct3 = 3'($urandom);
                bus.funct7b5 = 1'($urandom);
            end
            reset = $urandom_range(0, 39) == 0;
            bus.MemReady = $urandom_range(0, 9) < 7;
            bus.Zero = 1'($urandom);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Moore-FSM control unit for the multicycle RV32I datapath, which has a shared instruction/data memory, IR/OldPC/A/Data/ALUOut registers and a single ALU. It sequences fetch, decode, execute, memory and writeback over 3-5 cycles per instruction. It stalls on a memory ready handshake and flags unsupported opcodes. Supported instructions: lw, sw, R-type (add/sub/and/or/slt), I-type ALU, beq, jal.

Parameters:
MEM_HANDSHAKE, 1, 1 = honour MemReady; 0 = treat MemReady as constant 1
RESET_STATE, S_FETCH, state entered on reset (fixed; exposed for bench only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
op  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7b5  in  1  IR[30]
Zero  in  1  ALU zero flag
MemReady  in  1  shared memory completes access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address mux: 0 = PC, 1 = ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR and OldPC enable
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = A
ALUSrcB  out  2  00 = WriteData, 01 = ImmExt, 10 = constant 4
ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
RegWrite  out  1  register file write enable
Illegal  out  1  one-cycle pulse: unsupported opcode decoded
State  out  4  current state encoding (debug/verification)

Behaviour:
- The state register updates on the rising clk edge. reset=1 at an edge sets the state to S_FETCH, from any state, including mid-memory access.
- While reset=1, PCWrite, IRWrite, RegWrite, MemWrite and Illegal are forced to 0. Other outputs follow the current state.
- After reset: State=S_FETCH, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00 (add).
- All outputs are Moore, decoded from state, except three:
  - ImmSrc is combinational from op.
  - PCWrite is gated by Zero and MemReady.
  - IRWrite is gated by MemReady.
- S_FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - MemReady=0: stay in S_FETCH. MemReady=1: go to S_DECODE.
- S_DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target goes to ALUOut). Next state by op:
  - 0000011 or 0100011 -> S_MEMADR
  - 0110011 -> S_EXECR
  - 0010011 -> S_EXECI
  - 1100011 -> S_BEQ
  - 1101111 -> S_JAL
  - any other op -> S_FETCH, with Illegal=1 for this cycle
- S_MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. op[5]=0 -> S_MEMREAD; op[5]=1 -> S_MEMWRITE.
- S_MEMREAD: AdrSrc=1, ResultSrc=00. Stay while MemReady=0; MemReady=1 -> S_MEMWB.
- S_MEMWB: ResultSrc=01, RegWrite=1, then S_FETCH.
- S_MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1.
  - MemWrite stays high while MemReady=0.
  - MemReady=1 -> S_FETCH.
- S_EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then S_ALUWB.
- S_EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then S_ALUWB.
- S_ALUWB: ResultSrc=00, RegWrite=1, then S_FETCH.
- S_BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=Zero, then S_FETCH.
- S_JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, then S_ALUWB (rd <- PC+4).
- Unlisted outputs are 0 in every state. No state leaves any output X.
- ImmSrc by op: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, else 00.
- ALU decode:
  - ALUOp 00 -> add; ALUOp 01 -> sub.
  - ALUOp 10, by funct3:
    - 000 -> sub if (op[5] & funct7b5), else add
    - 010 -> slt
    - 110 -> or
    - 111 -> and
    - other funct3 -> add (no trap)
  - ALUOp 11 -> add.
- Latencies with MemReady=1: lw 5, sw 4, R/I 4, beq 3, jal 4 cycles. Each wait cycle adds 1.
- Unused state encodings -> S_FETCH next cycle; all write enables 0 while in one.

Decomposition:
- Shared package rv32_ctrl_pkg:
  - state_t enum (S_FETCH=0 ... S_JAL=10)
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL
  - mux-select localparams for ALUSrcA/B, ResultSrc and ImmSrc
  - ALUControl codes
- One natural sub-module: mainfsm (state register, next-state logic, Moore outputs, ALUOp).
- The existing aludec is instantiated unchanged for ALUControl. ImmSrc decode stays inline.

Test Plan:
- Reset, then lw (op=0000011), MemReady=1 throughout -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. RegWrite=1 only in cycle 5, ResultSrc=01.
- sw with MemReady held 0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, AdrSrc=1, then FETCH. PCWrite=0 throughout.
- R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECR. The same with funct7b5=0 -> 000. RegWrite pulses once in ALUWB.
- beq with Zero=1 then Zero=0 -> PCWrite=1 and 0 respectively in the BEQ cycle. 3-cycle instruction, ImmSrc=10.
- op=1110011 -> Illegal=1 for exactly one cycle in DECODE, next state FETCH, no write enables asserted.
- reset asserted during MEMWRITE with MemReady=0 -> MemWrite=0 that cycle, State=FETCH after the edge, IRWrite follows MemReady afterwards.
